// File: rtl/mux2_arb_pkg.sv
// Shared types for the two-requester round-robin mux arbiter.
// Sel encoding matches the mux2 cell: 0 passes A, 1 passes B.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    function automatic state_t busy_of(input logic side);
        return (side == SEL_B) ? BUSY_B : BUSY_A;
    endfunction

endpackage

// File: rtl/rr2_pick.sv
// Two-way priority pick: req[0]=A, req[1]=B; on contention pri chooses the winner.
// Purely combinational; grant uses the Sel encoding.
module rr2_pick
    import mux2_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       pri,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = SEL_A;
        if (&req) begin
            grant = pri;
        end else if (req[1]) begin
            grant = SEL_B;
        end
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin share of one mux2 datapath between A and B; 1-cycle accept-to-Y_valid latency.
// Single-entry output register; granted *_ready drops whenever the register is full and Y_ready=0.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit LOCK  = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             A_valid,
    input  logic [WIDTH-1:0] A_data,
    input  logic             A_last,
    output logic             A_ready,
    input  logic             B_valid,
    input  logic [WIDTH-1:0] B_data,
    input  logic             B_last,
    output logic             B_ready,
    output logic             Y_valid,
    output logic [WIDTH-1:0] Y_data,
    output logic             Y_last,
    input  logic             Y_ready,
    output logic             Sel
);

    state_t           state;
    logic             pri;
    logic             space;
    logic             a_fire;
    logic             b_fire;
    logic             fire;
    logic [WIDTH-1:0] mux_data;
    logic             mux_last;
    logic             release_now;
    logic             pick_pri;
    logic             pick_grant;
    logic             pick_valid;

    assign space   = ~Y_valid | Y_ready;
    assign A_ready = (state == BUSY_A) & space & ~RST;
    assign B_ready = (state == BUSY_B) & space & ~RST;
    assign a_fire  = A_valid & A_ready;
    assign b_fire  = B_valid & B_ready;
    assign fire    = a_fire | b_fire;

    // The shared mux2: Sel is the grant, so it already points at the accepted side.
    assign mux_data = (Sel == SEL_B) ? B_data : A_data;
    assign mux_last = (Sel == SEL_B) ? B_last : A_last;

    assign release_now = fire & ((LOCK == 1'b0) | mux_last);

    // On release the other side is preferred, so the same picker serves both cases.
    assign pick_pri = (state == IDLE) ? pri : ~Sel;

    rr2_pick u_pick (
        .req   ({B_valid, A_valid}),
        .pri   (pick_pri),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            Sel     <= SEL_A;
            pri     <= 1'b0;
            Y_valid <= 1'b0;
            Y_data  <= '0;
            Y_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state <= busy_of(pick_grant);
                        Sel   <= pick_grant;
                    end
                end
                BUSY_A, BUSY_B: begin
                    if (release_now) begin
                        pri <= ~Sel;
                        if (pick_valid) begin
                            state <= busy_of(pick_grant);
                            Sel   <= pick_grant;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (fire) begin
                Y_valid <= 1'b1;
                Y_data  <= mux_data;
                Y_last  <= mux_last;
            end else if (Y_ready) begin
                Y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: a LOCK=1 instance driven by packet queues and a LOCK=0 instance held in contention.
module tb_mux2_rr_arbiter;
    import mux2_arb_pkg::*;

    logic       clk;
    logic       rst;
    logic       a_valid, a_last, a_ready;
    logic [7:0] a_data;
    logic       b_valid, b_last, b_ready;
    logic [7:0] b_data;
    logic       y_valid, y_last, y_ready, sel;
    logic [7:0] y_data;

    logic       n_a_ready, n_b_ready, n_y_valid, n_y_last, n_sel;
    logic [7:0] n_y_data;

    int n_tests = 0;
    int n_fail  = 0;

    int pa[$], pal[$], pb[$], pbl[$];
    int ia, ib, cyc, stall_s, stall_n;
    int yq[$], ylq[$], ycyc[$];
    int yv_log[$], yd_log[$], ar_log[$], br_log[$], sel_log[$], pri_log[$], st_log[$];
    int nsel_log[$], nyd_log[$], nar_log[$], nbr_log[$], nyl_log[$];

    mux2_rr_arbiter #(.WIDTH(8), .LOCK(1'b1)) u_lock (
        .CLK(clk), .RST(rst),
        .A_valid(a_valid), .A_data(a_data), .A_last(a_last), .A_ready(a_ready),
        .B_valid(b_valid), .B_data(b_data), .B_last(b_last), .B_ready(b_ready),
        .Y_valid(y_valid), .Y_data(y_data), .Y_last(y_last), .Y_ready(y_ready),
        .Sel(sel)
    );

    mux2_rr_arbiter #(.WIDTH(8), .LOCK(1'b0)) u_nolock (
        .CLK(clk), .RST(rst),
        .A_valid(1'b1), .A_data(8'hA0), .A_last(1'b0), .A_ready(n_a_ready),
        .B_valid(1'b1), .B_data(8'hB0), .B_last(1'b0), .B_ready(n_b_ready),
        .Y_valid(n_y_valid), .Y_data(n_y_data), .Y_last(n_y_last), .Y_ready(1'b1),
        .Sel(n_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic drive_srcs();
        a_valid = (ia < pa.size());
        a_data  = a_valid ? 8'(pa[ia]) : 8'h00;
        a_last  = a_valid ? pal[ia][0] : 1'b0;
        b_valid = (ib < pb.size());
        b_data  = b_valid ? 8'(pb[ib]) : 8'h00;
        b_last  = b_valid ? pbl[ib][0] : 1'b0;
    endtask

    task automatic clear_logs();
        yq.delete(); ylq.delete(); ycyc.delete();
        yv_log.delete(); yd_log.delete(); ar_log.delete(); br_log.delete();
        sel_log.delete(); pri_log.delete(); st_log.delete();
        nsel_log.delete(); nyd_log.delete(); nar_log.delete(); nbr_log.delete(); nyl_log.delete();
        cyc = 0;
        stall_n = 0;
        y_ready = 1'b1;
    endtask

    // One clock: observe at the falling edge, advance sources just after the rising edge.
    task automatic step();
        bit acc_a, acc_b;
        @(negedge clk);
        acc_a = a_valid & a_ready;
        acc_b = b_valid & b_ready;
        if (y_valid & y_ready) begin
            yq.push_back(int'(y_data));
            ylq.push_back(int'(y_last));
            ycyc.push_back(cyc);
        end
        yv_log.push_back(int'(y_valid));
        yd_log.push_back(int'(y_data));
        ar_log.push_back(int'(a_ready));
        br_log.push_back(int'(b_ready));
        sel_log.push_back(int'(sel));
        pri_log.push_back(int'(u_lock.pri));
        st_log.push_back(int'(u_lock.state));
        nsel_log.push_back(int'(n_sel));
        nyd_log.push_back(int'(n_y_data));
        nar_log.push_back(int'(n_a_ready));
        nbr_log.push_back(int'(n_b_ready));
        nyl_log.push_back(int'(n_y_last & n_y_valid));
        @(posedge clk);
        #1;
        cyc++;
        if (acc_a) ia++;
        if (acc_b) ib++;
        y_ready = !(cyc >= stall_s && cyc < stall_s + stall_n);
        drive_srcs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ia = 0;
        ib = 0;
        drive_srcs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    initial begin
        int exp_y[6];
        rst = 1'b1;
        y_ready = 1'b1;
        stall_s = 0;
        stall_n = 0;
        cyc = 0;
        ia = 0;
        ib = 0;

        // Reset held two cycles with both requesters valid
        pa = '{'h11, 'h12, 'h13}; pal = '{0, 0, 1};
        pb = '{'h21, 'h22, 'h23}; pbl = '{0, 0, 1};
        drive_srcs();
        @(posedge clk);
        #1;
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            check("rst_y_valid", yv_log[k], 0);
            check("rst_sel", sel_log[k], 0);
            check("rst_a_ready", ar_log[k], 0);
            check("rst_b_ready", br_log[k], 0);
        end
        rst = 1'b0;
        clear_logs();

        // Contention with LOCK=1: whole A packet, then whole B packet
        repeat (10) step();
        check("idle_a_ready_c0", ar_log[0], 0);
        check("grant_a_ready_c1", ar_log[1], 1);
        check("grant_sel_c1", sel_log[1], 0);
        exp_y = '{'h11, 'h12, 'h13, 'h21, 'h22, 'h23};
        check("lock_count", yq.size(), 6);
        for (int k = 0; k < 6; k++) check("lock_y_data", qat(yq, k), exp_y[k]);
        check("lock_last_mid", qat(ylq, 1), 0);
        check("lock_last_a", qat(ylq, 2), 1);
        check("lock_last_b", qat(ylq, 5), 1);
        check("lock_no_gap", qat(ycyc, 5) - qat(ycyc, 0), 5);
        check("lock_sel_before", sel_log[3], 0);
        check("lock_sel_after", sel_log[4], 1);
        check("lock_pri_after_a", pri_log[4], 1);

        // LOCK=0 instance under continuous contention over the same cycles
        for (int k = 1; k <= 6; k++) check("nolock_sel", nsel_log[k], (k - 1) % 2);
        for (int k = 2; k <= 6; k++) check("nolock_y_data", nyd_log[k], (k % 2 == 0) ? 'hA0 : 'hB0);
        check("nolock_a_ready", nar_log[1], 1);
        check("nolock_b_ready", nbr_log[2], 1);
        check("nolock_y_last", nyl_log[3], 0);

        // Backpressure: Y_ready low for cycles 3..6 while 0x32 sits in the register
        pa = '{'h31, 'h32, 'h33, 'h34}; pal = '{0, 0, 0, 1};
        pb.delete(); pbl.delete();
        do_reset();
        stall_s = 3;
        stall_n = 4;
        repeat (12) step();
        check("bp_hold_data_c4", yd_log[4], 'h32);
        check("bp_hold_data_c6", yd_log[6], 'h32);
        check("bp_hold_valid_c6", yv_log[6], 1);
        check("bp_a_ready_c4", ar_log[4], 0);
        check("bp_a_ready_c6", ar_log[6], 0);
        check("bp_count", yq.size(), 4);
        for (int k = 0; k < 4; k++) check("bp_y_data", qat(yq, k), 'h31 + k);

        // Reset after two of three A beats, then a fresh B packet
        pa = '{'h41, 'h42, 'h43}; pal = '{0, 0, 1};
        do_reset();
        repeat (3) step();
        check("mid_accepted", ia, 2);
        rst = 1'b1;
        step();
        check("mid_rst_a_ready", ar_log[3], 0);
        rst = 1'b0;
        pa.delete(); pal.delete();
        ia = 0;
        pb = '{'h51, 'h52}; pbl = '{0, 1};
        ib = 0;
        clear_logs();
        drive_srcs();
        repeat (5) step();
        check("mid_y_valid", yv_log[0], 0);
        check("mid_y_data", yd_log[0], 0);
        check("mid_state", st_log[0], int'(IDLE));
        check("mid_sel_b", sel_log[1], 1);
        check("mid_count", yq.size(), 2);
        check("mid_y0", qat(yq, 0), 'h51);
        check("mid_y1", qat(yq, 1), 'h52);

        // Lone requester B, two packets back to back
        pb = '{'h61, 'h62, 'h63, 'h64}; pbl = '{0, 1, 0, 1};
        do_reset();
        repeat (8) step();
        check("lone_count", yq.size(), 4);
        for (int k = 0; k < 4; k++) check("lone_y_data", qat(yq, k), 'h61 + k);
        check("lone_no_gap", qat(ycyc, 3) - qat(ycyc, 0), 3);
        for (int k = 1; k <= 4; k++) check("lone_sel", sel_log[k], 1);
        check("lone_b_ready_c3", br_log[3], 1);
        check("lone_pri", pri_log[7], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
